// File: rtl/fm_axi_m_pkg.sv
// Shared AXI3 master channel widths for the fm_axi_m bridge.
package fm_axi_m_pkg;

    localparam int unsigned P_AXI_M_AWID    = 4;
    localparam int unsigned P_AXI_M_AWADDR  = 32;
    localparam int unsigned P_AXI_M_AWLEN   = 4;
    localparam int unsigned P_AXI_M_AWSIZE  = 3;
    localparam int unsigned P_AXI_M_AWBURST = 2;
    localparam int unsigned P_AXI_M_AWLOCK  = 2;
    localparam int unsigned P_AXI_M_AWCACHE = 4;
    localparam int unsigned P_AXI_M_AWPROT  = 3;
    localparam int unsigned P_AXI_M_WDATA   = 32;
    localparam int unsigned P_AXI_M_WSTRB   = 4;
    localparam int unsigned P_AXI_M_BRESP   = 2;

endpackage

// File: rtl/fm_axi_m.sv
// AXI3 master bridge: one internal-bus word access becomes one single-beat AXI
// transaction; only one transaction is ever outstanding.
module fm_axi_m
    import fm_axi_m_pkg::*;
#(
    parameter logic [P_AXI_M_AWID-1:0]    P_ID    = '0,
    parameter logic [P_AXI_M_AWCACHE-1:0] P_CACHE = 4'b0011
) (
    input  logic                         clk_core,
    input  logic                         rst_x,
    input  logic                         i_req,
    input  logic                         i_wr,
    input  logic [31:0]                  i_adrs,
    output logic                         o_ack,
    input  logic [3:0]                   i_be,
    input  logic [31:0]                  i_wd,
    output logic                         o_rstr,
    output logic [31:0]                  o_rd,
    output logic                         o_err,
    input  logic                         i_err_clr,
    output logic [P_AXI_M_AWID-1:0]      o_awid_m,
    output logic [P_AXI_M_AWADDR-1:0]    o_awaddr_m,
    output logic [P_AXI_M_AWLEN-1:0]     o_awlen_m,
    output logic [P_AXI_M_AWSIZE-1:0]    o_awsize_m,
    output logic [P_AXI_M_AWBURST-1:0]   o_awburst_m,
    output logic [P_AXI_M_AWLOCK-1:0]    o_awlock_m,
    output logic [P_AXI_M_AWCACHE-1:0]   o_awcache_m,
    output logic [P_AXI_M_AWPROT-1:0]    o_awprot_m,
    output logic                         o_awvalid_m,
    input  logic                         i_awready_m,
    output logic [P_AXI_M_AWID-1:0]      o_wid_m,
    output logic [P_AXI_M_WDATA-1:0]     o_wdata_m,
    output logic [P_AXI_M_WSTRB-1:0]     o_wstrb_m,
    output logic                         o_wlast_m,
    output logic                         o_wvalid_m,
    input  logic                         i_wready_m,
    input  logic [P_AXI_M_AWID-1:0]      i_bid_m,
    input  logic [P_AXI_M_BRESP-1:0]     i_bresp_m,
    input  logic                         i_bvalid_m,
    output logic                         o_bready_m,
    output logic [P_AXI_M_AWID-1:0]      o_arid_m,
    output logic [P_AXI_M_AWADDR-1:0]    o_araddr_m,
    output logic [P_AXI_M_AWLEN-1:0]     o_arlen_m,
    output logic [P_AXI_M_AWSIZE-1:0]    o_arsize_m,
    output logic [P_AXI_M_AWBURST-1:0]   o_arburst_m,
    output logic [P_AXI_M_AWLOCK-1:0]    o_arlock_m,
    output logic [P_AXI_M_AWCACHE-1:0]   o_arcache_m,
    output logic [P_AXI_M_AWPROT-1:0]    o_arprot_m,
    output logic                         o_arvalid_m,
    input  logic                         i_arready_m,
    input  logic [P_AXI_M_AWID-1:0]      i_rid_m,
    input  logic [P_AXI_M_WDATA-1:0]     i_rdata_m,
    input  logic [P_AXI_M_BRESP-1:0]     i_rresp_m,
    input  logic                         i_rlast_m,
    input  logic                         i_rvalid_m,
    output logic                         o_rready_m
);

    localparam logic [P_AXI_M_AWSIZE-1:0]  P_SIZE_WORD  = 3'b010;
    localparam logic [P_AXI_M_AWBURST-1:0] P_BURST_INCR = 2'b01;
    localparam logic [P_AXI_M_BRESP-1:0]   P_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {StIdle, StWa, StWb, StRa, StRd} state_e;

    state_e      state_q, state_d;
    logic [29:0] adrs_q, adrs_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wd_q, wd_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        rstr_q, rstr_d;
    logic [31:0] rd_q, rd_d;
    logic        err_q, err_d;
    logic        new_err;
    logic        aw_hs, w_hs;

    // Returned IDs and the sub-word address bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{i_bid_m, i_rid_m, i_adrs[1:0]};

    assign aw_hs = awvalid_q & i_awready_m;
    assign w_hs  = wvalid_q & i_wready_m;
    assign o_ack = (state_q == StIdle) & i_req;

    always_comb begin
        state_d   = state_q;
        adrs_d    = adrs_q;
        be_d      = be_q;
        wd_d      = wd_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rstr_d    = 1'b0;
        rd_d      = rd_q;
        new_err   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_req) begin
                    adrs_d    = i_adrs[31:2];
                    be_d      = i_be;
                    wd_d      = i_wd;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (i_wr) begin
                        state_d   = StWa;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRa;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWa: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Leave on whichever handshake completes the pair.
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    state_d  = StWb;
                    bready_d = 1'b1;
                end
            end
            StWb: begin
                if (i_bvalid_m) begin
                    state_d  = StIdle;
                    bready_d = 1'b0;
                    new_err  = (i_bresp_m != P_RESP_OKAY);
                end
            end
            StRa: begin
                if (i_arready_m) begin
                    state_d   = StRd;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRd: begin
                if (i_rvalid_m) begin
                    state_d  = StIdle;
                    rready_d = 1'b0;
                    rd_d     = i_rdata_m;
                    rstr_d   = 1'b1;
                    new_err  = (i_rresp_m != P_RESP_OKAY) | ~i_rlast_m;
                end
            end
            default: state_d = StIdle;
        endcase
        // A fresh error outranks a simultaneous clear.
        err_d = (err_q & ~i_err_clr) | new_err;
    end

    always_ff @(posedge clk_core or negedge rst_x) begin
        if (!rst_x) begin
            state_q   <= StIdle;
            adrs_q    <= '0;
            be_q      <= '0;
            wd_q      <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rstr_q    <= 1'b0;
            rd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            adrs_q    <= adrs_d;
            be_q      <= be_d;
            wd_q      <= wd_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rstr_q    <= rstr_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
        end
    end

    assign o_awid_m    = P_ID;
    assign o_awaddr_m  = {adrs_q, 2'b00};
    assign o_awlen_m   = '0;
    assign o_awsize_m  = P_SIZE_WORD;
    assign o_awburst_m = P_BURST_INCR;
    assign o_awlock_m  = '0;
    assign o_awcache_m = P_CACHE;
    assign o_awprot_m  = '0;
    assign o_awvalid_m = awvalid_q;
    assign o_wid_m     = P_ID;
    assign o_wdata_m   = wd_q;
    assign o_wstrb_m   = be_q;
    assign o_wlast_m   = 1'b1;
    assign o_wvalid_m  = wvalid_q;
    assign o_bready_m  = bready_q;
    assign o_arid_m    = P_ID;
    assign o_araddr_m  = {adrs_q, 2'b00};
    assign o_arlen_m   = '0;
    assign o_arsize_m  = P_SIZE_WORD;
    assign o_arburst_m = P_BURST_INCR;
    assign o_arlock_m  = '0;
    assign o_arcache_m = P_CACHE;
    assign o_arprot_m  = '0;
    assign o_arvalid_m = arvalid_q;
    assign o_rready_m  = rready_q;
    assign o_rstr      = rstr_q;
    assign o_rd        = rd_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_fm_axi_m.sv
// Randomised bench for fm_axi_m: the bench plays requester and AXI fabric and
// checks every transaction against a transaction-level model.
module tb_fm_axi_m;

    logic        clk_core = 1'b0;
    logic        rst_x;
    logic        i_req, i_wr, o_ack, o_rstr, o_err, i_err_clr;
    logic [31:0] i_adrs, i_wd, o_rd;
    logic [3:0]  i_be;
    logic [3:0]  o_awid_m, o_awlen_m, o_awcache_m, o_wid_m, o_wstrb_m;
    logic [31:0] o_awaddr_m, o_wdata_m, o_araddr_m, i_rdata_m;
    logic [2:0]  o_awsize_m, o_awprot_m, o_arsize_m, o_arprot_m;
    logic [1:0]  o_awburst_m, o_awlock_m, o_arburst_m, o_arlock_m;
    logic        o_awvalid_m, i_awready_m, o_wlast_m, o_wvalid_m, i_wready_m;
    logic [3:0]  i_bid_m, o_arid_m, o_arlen_m, o_arcache_m, i_rid_m;
    logic [1:0]  i_bresp_m, i_rresp_m;
    logic        i_bvalid_m, o_bready_m, o_arvalid_m, i_arready_m;
    logic        i_rlast_m, i_rvalid_m, o_rready_m;

    int   checks = 0;
    int   failures = 0;
    logic err_m = 1'b0;
    logic clr_rand = 1'b0;

    always #5 clk_core = ~clk_core;

    fm_axi_m u_dut (
        .clk_core(clk_core), .rst_x(rst_x),
        .i_req(i_req), .i_wr(i_wr), .i_adrs(i_adrs), .o_ack(o_ack),
        .i_be(i_be), .i_wd(i_wd), .o_rstr(o_rstr), .o_rd(o_rd),
        .o_err(o_err), .i_err_clr(i_err_clr),
        .o_awid_m(o_awid_m), .o_awaddr_m(o_awaddr_m), .o_awlen_m(o_awlen_m),
        .o_awsize_m(o_awsize_m), .o_awburst_m(o_awburst_m), .o_awlock_m(o_awlock_m),
        .o_awcache_m(o_awcache_m), .o_awprot_m(o_awprot_m),
        .o_awvalid_m(o_awvalid_m), .i_awready_m(i_awready_m),
        .o_wid_m(o_wid_m), .o_wdata_m(o_wdata_m), .o_wstrb_m(o_wstrb_m),
        .o_wlast_m(o_wlast_m), .o_wvalid_m(o_wvalid_m), .i_wready_m(i_wready_m),
        .i_bid_m(i_bid_m), .i_bresp_m(i_bresp_m), .i_bvalid_m(i_bvalid_m),
        .o_bready_m(o_bready_m),
        .o_arid_m(o_arid_m), .o_araddr_m(o_araddr_m), .o_arlen_m(o_arlen_m),
        .o_arsize_m(o_arsize_m), .o_arburst_m(o_arburst_m), .o_arlock_m(o_arlock_m),
        .o_arcache_m(o_arcache_m), .o_arprot_m(o_arprot_m),
        .o_arvalid_m(o_arvalid_m), .i_arready_m(i_arready_m),
        .i_rid_m(i_rid_m), .i_rdata_m(i_rdata_m), .i_rresp_m(i_rresp_m),
        .i_rlast_m(i_rlast_m), .i_rvalid_m(i_rvalid_m), .o_rready_m(o_rready_m)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic pick_clr(input logic force_clr);
        return force_clr || (clr_rand && ($urandom_range(0, 7) == 0));
    endfunction

    task automatic fabric_quiet();
        i_awready_m = 1'b0; i_wready_m = 1'b0; i_bvalid_m = 1'b0; i_arready_m = 1'b0;
        i_rvalid_m = 1'b0; i_bresp_m = 2'b00; i_rresp_m = 2'b00; i_rlast_m = 1'b1;
        i_bid_m = 4'h0; i_rid_m = 4'h0; i_rdata_m = 32'h0;
    endtask

    task automatic idle_cycles(input int n, input logic clr);
        for (int i = 0; i < n; i++) begin
            i_req = 1'b0;
            i_err_clr = clr | pick_clr(1'b0);
            err_m = err_m & ~i_err_clr;
            @(negedge clk_core);
            check_eq("err_idle", o_err, err_m);
            check_eq("rstr_idle", o_rstr, 0);
        end
        i_err_clr = 1'b0;
    endtask

    // One complete transaction; for reads a_dly/b_dly are the AR and R delays.
    task automatic do_txn(input logic wr, input logic [31:0] adrs, input logic [3:0] be,
                          input logic [31:0] wd, input int a_dly, input int w_dly,
                          input int b_dly, input logic [1:0] resp, input logic rlast,
                          input logic [31:0] rdata, input logic force_clr);
        int   n, k, a_k, w_k, last_k;
        logic a_seen, w_seen, done, new_err;
        i_req = 1'b1; i_wr = wr; i_adrs = adrs; i_be = be; i_wd = wd;
        i_err_clr = pick_clr(1'b0);
        #1;
        n = 0;
        while (!o_ack && n < 20) begin
            err_m = err_m & ~i_err_clr;
            @(negedge clk_core);
            i_err_clr = pick_clr(1'b0);
            #1;
            n++;
        end
        check_eq("ack_latency", n, 0);
        if (!o_ack) return;
        err_m = err_m & ~i_err_clr;
        @(negedge clk_core);
        a_seen = 1'b0; w_seen = 1'b0; done = 1'b0; k = 0; a_k = 0; w_k = 0;
        while (!done && k < 40) begin
            k++;
            check_eq("err", o_err, err_m);
            check_eq("rstr_busy", o_rstr, 0);
            if (wr) begin
                check_eq("awvalid", o_awvalid_m, !a_seen);
                check_eq("wvalid", o_wvalid_m, !w_seen);
                check_eq("bready", o_bready_m, a_seen && w_seen);
                check_eq("arvalid_in_write", o_arvalid_m, 0);
                if (o_awvalid_m) check_eq("awaddr", o_awaddr_m, adrs & ~32'h3);
                if (o_wvalid_m) begin
                    check_eq("wdata", o_wdata_m, wd);
                    check_eq("wstrb", o_wstrb_m, be);
                end
            end else begin
                check_eq("arvalid", o_arvalid_m, !a_seen);
                check_eq("rready", o_rready_m, a_seen);
                check_eq("aw_w_in_read", {o_awvalid_m, o_wvalid_m, o_bready_m}, 0);
                if (o_arvalid_m) check_eq("araddr", o_araddr_m, adrs & ~32'h3);
            end
            // Requester may keep asking (with changing payload) while busy.
            i_req = 1'($urandom_range(0, 1)); i_wr = 1'($urandom_range(0, 1));
            i_adrs = $urandom; i_wd = $urandom; i_be = 4'($urandom);
            last_k = (a_k > w_k) ? a_k : w_k;
            i_awready_m = wr && (k > a_dly);
            i_wready_m  = wr && (k > w_dly);
            i_bvalid_m  = wr && a_seen && w_seen && (k >= last_k + 1 + b_dly);
            i_bresp_m   = resp;
            i_bid_m     = 4'($urandom);
            i_arready_m = !wr && (k > a_dly);
            i_rvalid_m  = !wr && a_seen && (k >= a_k + 1 + b_dly);
            i_rdata_m   = i_rvalid_m ? rdata : $urandom;
            i_rresp_m   = resp;
            i_rlast_m   = rlast;
            i_rid_m     = 4'($urandom);
            i_err_clr   = pick_clr(force_clr);
            new_err     = 1'b0;
            #1;
            check_eq("ack_busy", o_ack, 0);
            if (wr) begin
                if (o_awvalid_m && i_awready_m) begin a_seen = 1'b1; a_k = k; end
                if (o_wvalid_m && i_wready_m) begin w_seen = 1'b1; w_k = k; end
                if (i_bvalid_m && o_bready_m) begin done = 1'b1; new_err = (resp != 2'b00); end
            end else begin
                if (o_arvalid_m && i_arready_m) begin a_seen = 1'b1; a_k = k; end
                if (i_rvalid_m && o_rready_m) begin
                    done = 1'b1;
                    new_err = (resp != 2'b00) || !rlast;
                end
            end
            err_m = (err_m & ~i_err_clr) | new_err;
            @(negedge clk_core);
        end
        check_eq("txn_done", done, 1);
        fabric_quiet();
        i_err_clr = 1'b0;
        check_eq("err_end", o_err, err_m);
        check_eq("valids_end", {o_awvalid_m, o_wvalid_m, o_arvalid_m, o_bready_m, o_rready_m}, 0);
        check_eq("rstr_end", o_rstr, !wr);
        if (!wr) check_eq("rd", o_rd, rdata);
        if (a_dly == 0 && w_dly == 0 && b_dly == 0) check_eq("zero_wait_cycles", k, 2);
    endtask

    initial begin
        logic        wr, rl;
        logic [1:0]  rsp;
        rst_x = 1'b1;
        i_req = 1'b0; i_wr = 1'b0; i_adrs = 32'h0; i_be = 4'h0; i_wd = 32'h0;
        i_err_clr = 1'b0;
        fabric_quiet();
        #2 rst_x = 1'b0;
        repeat (3) @(negedge clk_core);
        check_eq("rst_valids", {o_awvalid_m, o_wvalid_m, o_arvalid_m, o_bready_m, o_rready_m}, 0);
        check_eq("rst_rstr_err", {o_rstr, o_err, o_ack}, 0);
        check_eq("rst_rd", o_rd, 0);
        check_eq("rst_awaddr", o_awaddr_m, 0);
        check_eq("rst_attr_aw", {o_awid_m, o_awlen_m, o_awsize_m, o_awburst_m, o_awlock_m,
                                 o_awcache_m, o_awprot_m}, {4'h0, 4'h0, 3'b010, 2'b01, 2'b00,
                                 4'b0011, 3'b000});
        check_eq("rst_attr_ar", {o_arid_m, o_arlen_m, o_arsize_m, o_arburst_m, o_arlock_m,
                                 o_arcache_m, o_arprot_m, o_wid_m, o_wlast_m},
                                {4'h0, 4'h0, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b000, 4'h0, 1'b1});
        rst_x = 1'b1;
        @(negedge clk_core);

        // Directed cases.
        do_txn(1'b1, 32'h0000_1004, 4'b0011, 32'hDEAD_BEEF, 0, 0, 0, 2'b00, 1'b1, 32'h0, 1'b0);
        do_txn(1'b1, 32'h3000_0013, 4'hF, 32'hA5A5_0F0F, 0, 3, 1, 2'b00, 1'b1, 32'h0, 1'b0);
        do_txn(1'b1, 32'h3000_0020, 4'h8, 32'h0BAD_F00D, 2, 0, 0, 2'b00, 1'b1, 32'h0, 1'b0);
        do_txn(1'b0, 32'h0000_2008, 4'h0, 32'h0, 2, 0, 0, 2'b00, 1'b1, 32'h1234_5678, 1'b0);
        idle_cycles(1, 1'b0);
        do_txn(1'b1, 32'h0000_0040, 4'hC, 32'h1111_2222, 0, 0, 0, 2'b10, 1'b1, 32'h0, 1'b0);
        idle_cycles(3, 1'b0);
        check_eq("err_sticky", o_err, 1);
        idle_cycles(1, 1'b1);
        check_eq("err_cleared", o_err, 0);
        do_txn(1'b0, 32'h0000_0080, 4'h0, 32'h0, 0, 0, 1, 2'b10, 1'b1, 32'hCAFE_0001, 1'b1);
        check_eq("err_set_wins", o_err, 1);
        idle_cycles(1, 1'b1);
        do_txn(1'b0, 32'h0000_00C4, 4'h0, 32'h0, 1, 0, 0, 2'b00, 1'b0, 32'hCAFE_0002, 1'b0);
        check_eq("err_rlast", o_err, 1);
        idle_cycles(1, 1'b1);
        // Back-to-back with i_req never dropped between transactions.
        do_txn(1'b0, 32'h0000_0100, 4'h0, 32'h0, 0, 0, 0, 2'b00, 1'b1, 32'h0000_0101, 1'b0);
        do_txn(1'b1, 32'h0000_0104, 4'h5, 32'h0000_0202, 1, 1, 0, 2'b00, 1'b1, 32'h0, 1'b0);
        do_txn(1'b0, 32'h0000_0108, 4'h0, 32'h0, 0, 0, 2, 2'b00, 1'b1, 32'h0000_0303, 1'b0);

        // Leave an error pending, then reset in the middle of a write address phase.
        do_txn(1'b1, 32'h0000_0200, 4'hF, 32'h5555_AAAA, 0, 0, 0, 2'b11, 1'b1, 32'h0, 1'b0);
        i_req = 1'b1; i_wr = 1'b1; i_adrs = 32'h0000_5004; i_be = 4'hF; i_wd = 32'h7777_8888;
        #1;
        check_eq("ack_pre_reset", o_ack, 1);
        @(negedge clk_core);
        i_req = 1'b0;
        check_eq("awvalid_pre_reset", o_awvalid_m, 1);
        #2 rst_x = 1'b0;
        #1;
        check_eq("reset_async_valids",
                 {o_awvalid_m, o_wvalid_m, o_arvalid_m, o_bready_m, o_rready_m}, 0);
        check_eq("reset_async_err", o_err, 0);
        err_m = 1'b0;
        @(negedge clk_core);
        rst_x = 1'b1;
        @(negedge clk_core);
        do_txn(1'b1, 32'h0000_6000, 4'h3, 32'h1357_9BDF, 0, 0, 0, 2'b00, 1'b1, 32'h0, 1'b0);
        do_txn(1'b0, 32'h0000_6004, 4'h0, 32'h0, 0, 0, 0, 2'b00, 1'b1, 32'h2468_ACE0, 1'b0);

        // Randomised traffic with random delays, responses and clears.
        clr_rand = 1'b1;
        for (int t = 0; t < 60; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap != 0) idle_cycles(gap, 1'b0);
            wr  = 1'($urandom_range(0, 1));
            rsp = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
            rl  = ($urandom_range(0, 7) != 0);
            do_txn(wr, $urandom, 4'($urandom), $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), rsp, rl, $urandom, 1'b0);
        end
        clr_rand = 1'b0;
        idle_cycles(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fm_axi_m.md
# fm_axi_m

AXI3 master bridge translating the single-word internal bus (req/wr/adrs/ack/be/wd/rstr/rd) into single-beat AXI write and read transactions. It is the initiator-side counterpart of the AXI slave bridge. Internal engines (DMA, display fetch) use it to reach system memory over the AXI fabric. Exactly one transaction is outstanding at a time, so the block needs no reorder logic and no FIFOs.

## Interface
Parameters:
- P_ID, default 0: constant value driven on o_awid_m, o_wid_m and o_arid_m.
- P_CACHE, default 4'b0011: constant value driven on o_awcache_m and o_arcache_m.

Ports:
- clk_core  in  1  clock.
- rst_x  in  1  reset, asynchronous, active-low.
- i_req  in  1  internal request.
- i_wr  in  1  request type: 1 = write, 0 = read.
- i_adrs  in  32  byte address; bits [1:0] are ignored.
- o_ack  out  1  request accepted (combinational).
- i_be  in  4  write byte enables.
- i_wd  in  32  write data.
- o_rstr  out  1  read data strobe, one-cycle pulse.
- o_rd  out  32  read data.
- o_err  out  1  sticky error: set by a non-OKAY response or by a read beat with rlast=0.
- i_err_clr  in  1  clears o_err.
- o_awid_m, o_awaddr_m, o_awlen_m, o_awsize_m, o_awburst_m, o_awlock_m, o_awcache_m, o_awprot_m  out  4/32/4/3/2/2/4/3  write address channel.
- o_awvalid_m  out  1  write address valid.
- i_awready_m  in  1  write address ready.
- o_wid_m  out  4  write ID.
- o_wdata_m  out  32  write data.
- o_wstrb_m  out  4  write strobes.
- o_wlast_m  out  1  tied 1.
- o_wvalid_m  out  1  write data valid.
- i_wready_m  in  1  write data ready.
- i_bid_m  in  4  write response ID.
- i_bresp_m  in  2  write response.
- i_bvalid_m  in  1  write response valid.
- o_bready_m  out  1  write response ready.
- o_arid_m, o_araddr_m, o_arlen_m, o_arsize_m, o_arburst_m, o_arlock_m, o_arcache_m, o_arprot_m  out  widths as AW  read address channel.
- o_arvalid_m  out  1  read address valid.
- i_arready_m  in  1  read address ready.
- i_rid_m  in  4  read ID.
- i_rdata_m  in  32  read data.
- i_rresp_m  in  2  read response.
- i_rlast_m  in  1  read last.
- i_rvalid_m  in  1  read valid.
- o_rready_m  out  1  read ready.

## Operation
- Fixed attributes: len=0, size=3'b010, burst=INCR (2'b01), lock=0, prot=0, cache=P_CACHE, id=P_ID.
- Address output is {captured_adrs[31:2], 2'b00}.
- o_ack = (state==IDLE) & i_req. On the same edge the block captures i_wr, i_adrs, i_be and i_wd.
- IDLE: on i_req, go to WA if i_wr=1, otherwise to RA.
- WA: o_awvalid_m and o_wvalid_m are both 1 on entry.
  - Each valid deasserts after its own handshake; flags r_aw_done and r_w_done record completion.
  - Handshakes may complete in the same cycle or in either order.
  - Go to WB on the cycle the last of the two handshakes completes.
- WB: o_bready_m=1. On i_bvalid_m, go to IDLE; set o_err if i_bresp_m != 2'b00.
- RA: o_arvalid_m=1. On i_arready_m, go to RD.
- RD: o_rready_m=1. On i_rvalid_m:
  - register i_rdata_m into o_rd and pulse o_rstr for the next cycle;
  - go to IDLE;
  - set o_err if i_rresp_m != 0 or i_rlast_m = 0.
- Returned i_bid_m and i_rid_m are ignored.
- o_err: i_err_clr and a new error in the same cycle leaves o_err set (set wins).
- Valid signals are held stable until their ready, as AXI requires. Payload registers do not change while any valid is high.

## Timing
- Reset: state=IDLE. Every output is 0 except the constant attribute fields: o_awvalid_m, o_wvalid_m, o_arvalid_m, o_bready_m, o_rready_m, o_rstr, o_err, o_rd = 0.
- All AXI outputs and o_rstr/o_rd are registered. o_ack is the only combinational output.
- Write with zero fabric wait: ack at T0, aw/w valid at T1, bready at T2, bvalid at T2 gives IDLE at T3. The next ack is possible at T3.
- Read with zero fabric wait: ack at T0, arvalid at T1, rready at T2, rvalid at T2 gives o_rstr=1 with o_rd valid at T3 and IDLE at T3.
- i_req held while not IDLE is not acked. The requester must keep i_req and its payload stable until o_ack.
- Reset mid-transaction drops all valids immediately. The fabric is reset by the same rst_x, so no recovery is required.

## Structure
- AXI width constants P_AXI_M_* (values as listed above) belong in the shared polyphony_axi_def.v.
- State encoding and fixed-attribute localparams stay local to the module.
- Single flat module, no sub-module. Expected RTL size is roughly 200 lines.

## Test plan
- Write 0x0000_1004, be=4'b0011, wd=0xDEADBEEF, awready/wready=1, bvalid at T2 -> awaddr=0x1004, wstrb=0x3, wdata=0xDEADBEEF, ack at T0 only, IDLE at T3, o_err=0.
- Write where wready comes 3 cycles after awready -> awvalid low after its handshake, wvalid held; exactly one AW and one W beat; bready asserts only after both complete.
- Read 0x0000_2008, arready delayed 2 cycles, rdata=0x12345678 rlast=1 -> araddr=0x2008 stable while waiting; o_rstr is a single pulse with o_rd=0x12345678.
- bresp=2'b10 -> o_err=1 and held. i_err_clr -> 0. Simultaneous clear and rresp=SLVERR -> o_err stays 1.
- Back-to-back i_req held continuously (read, write, read) -> exactly one ack per transaction, none while busy; AXI sees strictly serialized transactions.
- rst_x asserted while in WA with awvalid high -> all valids 0 asynchronously; after release, IDLE and the next request is handled normally.
